exc_step4_ctrl: RTL and testbench
=================================

# exc_step4_ctrl

Parametrised memory-stage (step 4) exception and interrupt controller for the pipelined core. Latches N external interrupt lines as pending, applies a software mask and fixed priority, and merges them with synchronous exceptions arriving from step 3. Taking an event captures EPC, cause and source ID, flushes the pipe, and redirects fetch to the handler vector; `eret` returns to EPC. Write-enable gating for data memory (`dm_w`) is produced here so no store retires under a taken event.

## Interface
- `N_IRQ`, 4: number of external interrupt lines (1..16).
- `CAUSE_W`, 3: cause code width.
- `ADDR_W`, 32: PC width.
- `VEC_ADDR`, 32'h0000_0180: handler entry PC.
- `IRQ_ID_W`: localparam, max(1, clog2(N_IRQ)).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq`  in  N_IRQ  level interrupt requests (synchronised upstream).
- `opcode`  in  6  step-4 instruction opcode.
- `pc_step4`  in  ADDR_W  PC of step-4 instruction.
- `cause_step3`  in  CAUSE_W  synchronous exception code; 0 = none.
- `eret`  in  1  return-from-exception in step 4.
- `mask_we`  in  1  write interrupt mask.
- `mask_wdata`  in  N_IRQ  new mask; 1 = enabled.
- `dm_w`  out  1  data-memory write enable.
- `load_step4`  out  1  step-4 register load enable.
- `cause_step4`  out  CAUSE_W  registered cause of last taken event.
- `irq_id`  out  IRQ_ID_W  source of last taken interrupt.
- `epc`  out  ADDR_W  captured PC.
- `flush_step4`  out  1  pipeline flush pulse.
- `redirect`  out  1  fetch redirect strobe.
- `redirect_pc`  out  ADDR_W  redirect target.
- `in_handler`  out  1  high while in HANDLER.
- `double_fault`  out  1  sticky error flag.

## Operation
- Reset: state IDLE; pending, mask, cause_step4, irq_id, epc, double_fault = 0; flush_step4 = redirect = in_handler = 0; redirect_pc = 0; load_step4 = 1.
- Pending: rising edge of `irq[i]` (vs. registered previous value) sets `pend[i]`; cleared only when channel i is taken. Edge and clear in same cycle: set wins.
- Eligible = pend & mask. Priority: lowest index wins.
- Mask write takes effect next cycle; masked lines stay pending.
- States:
  - IDLE: if `cause_step3 != 0` → FLUSH, cause_step4 = cause_step3, epc = pc_step4 (exception beats interrupt; interrupt stays pending). Else if eligible ≠ 0 → FLUSH, cause_step4 = 0 (CAUSE_IRQ), irq_id = winner, clear pend[winner], epc = pc_step4. `eret` in IDLE ignored.
  - FLUSH (1 cycle): flush_step4 = redirect = 1, redirect_pc = VEC_ADDR, load_step4 = 0 → HANDLER.
  - HANDLER: in_handler = 1; interrupts not taken (remain pending). `cause_step3 != 0` sets double_fault (sticky until reset), no state change. `eret` → RETURN.
  - RETURN (1 cycle): flush_step4 = redirect = 1, redirect_pc = epc, load_step4 = 0 → IDLE.
- `eret` and `cause_step3 != 0` together in HANDLER: double_fault set and RETURN taken.
- `dm_w` = 1 only when opcode = OPCODE_SW, state ∈ {IDLE, HANDLER}, and no event taken this cycle; always 0 for EMPTY/SYSCALL.

## Timing
- Event sampled in IDLE at cycle T: cause/epc/irq_id valid from T+1; flush_step4/redirect high during T+1 only; HANDLER from T+2.
- `eret` at cycle T in HANDLER: redirect to epc during T+1; IDLE at T+2; a still-pending enabled irq may be taken at T+2 (FLUSH at T+3).
- `dm_w`: combinational, same cycle as opcode.
- Reset asserted mid-FLUSH/RETURN: all outputs to reset values immediately; no redirect completes.

## Structure
- Package `exc_pkg`: state enum (IDLE, FLUSH, HANDLER, RETURN), CAUSE_IRQ = 0, cause code constants; opcodes from `opcodes.vh`.
- Sub-module `irq_pending_prio`: edge detect, pending bits, mask register, priority encoder; outputs `any_eligible`, `winner_id`; input `take_clr`.

## Test plan
- Reset release, irq = 0, opcode = SW → dm_w = 1, all status outputs 0.
- mask = 4'b1111, irq[2] and irq[1] rise together, pc_step4 = 0x40 → FLUSH next cycle, irq_id = 1, cause_step4 = 0, epc = 0x40, redirect_pc = 0x180; pend[2] remains set.
- cause_step3 = 3 with irq[0] pending and enabled → cause_step4 = 3, pend[0] kept; dm_w = 0 in event cycle.
- HANDLER, eret at T → redirect_pc = epc at T+1, IDLE at T+2, pending irq[2] taken with FLUSH at T+3.
- mask = 0, irq[3] rises → no event; mask_we with 4'b1000 → FLUSH two cycles later, irq_id = 3.
- cause_step3 = 5 while in HANDLER → double_fault = 1 and stays 1; reset asserted mid-FLUSH → flush_step4, redirect 0 at once.

Source files
------------

// File: rtl/exc_step4_ctrl_pkg.sv
// ============================================================================
// Module : exc_pkg
// Brief  : Shared types and constants for the step-4 exception controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } state_t;

  // Cause codes; zero doubles as "no exception" on the step-3 input
  localparam int CAUSE_IRQ      = 0;
  localparam int CAUSE_ADEL     = 1;
  localparam int CAUSE_ADES     = 2;
  localparam int CAUSE_SYSCALL  = 3;
  localparam int CAUSE_BREAK    = 4;
  localparam int CAUSE_RI       = 5;
  localparam int CAUSE_OVF      = 6;

  // Opcode values mirror the core's opcodes.vh
  localparam logic [5:0] OPCODE_EMPTY   = 6'h00;
  localparam logic [5:0] OPCODE_SYSCALL = 6'h0C;
  localparam logic [5:0] OPCODE_LW      = 6'h23;
  localparam logic [5:0] OPCODE_SW      = 6'h2B;

  function automatic int irq_id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/exc_step4_ctrl_if.sv
// ============================================================================
// Module : exc_step4_ctrl_if
// Brief  : Pipeline-side bundle between step 4 and the exception controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface exc_step4_ctrl_if
  import exc_pkg::*;
#(
  parameter int N_IRQ   = 4,
  parameter int CAUSE_W = 3,
  parameter int ADDR_W  = 32
);
  localparam int IRQ_ID_W = irq_id_width(N_IRQ);

  logic [N_IRQ-1:0]    irq;
  logic [5:0]          opcode;
  logic [ADDR_W-1:0]   pc_step4;
  logic [CAUSE_W-1:0]  cause_step3;
  logic                eret;
  logic                mask_we;
  logic [N_IRQ-1:0]    mask_wdata;

  logic                dm_w;
  logic                load_step4;
  logic [CAUSE_W-1:0]  cause_step4;
  logic [IRQ_ID_W-1:0] irq_id;
  logic [ADDR_W-1:0]   epc;
  logic                flush_step4;
  logic                redirect;
  logic [ADDR_W-1:0]   redirect_pc;
  logic                in_handler;
  logic                double_fault;

  modport master (
    output irq, opcode, pc_step4, cause_step3, eret, mask_we, mask_wdata,
    input  dm_w, load_step4, cause_step4, irq_id, epc, flush_step4,
           redirect, redirect_pc, in_handler, double_fault
  );

  modport slave (
    input  irq, opcode, pc_step4, cause_step3, eret, mask_we, mask_wdata,
    output dm_w, load_step4, cause_step4, irq_id, epc, flush_step4,
           redirect, redirect_pc, in_handler, double_fault
  );

endinterface

`default_nettype wire

// File: rtl/exc_step4_ctrl_irq_pending_prio.sv
// ============================================================================
// Module : irq_pending_prio
// Brief  : Rising-edge latch of IRQ lines, mask register, lowest-index priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_pending_prio #(
  parameter int N_IRQ    = 4,
  parameter int IRQ_ID_W = 2
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic [N_IRQ-1:0]    irq,
  input  wire logic                mask_we,
  input  wire logic [N_IRQ-1:0]    mask_wdata,
  input  wire logic                take_clr,
  output logic                     any_eligible,
  output logic [IRQ_ID_W-1:0]      winner_id
);

  logic [N_IRQ-1:0] r_irq_prev;
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_eligible;

  assign w_rise     = irq & ~r_irq_prev;
  assign w_eligible = r_pend & r_mask;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_clr[i] = take_clr && (winner_id == IRQ_ID_W'(i));
    end
  end

  // Walking downwards leaves the lowest eligible index as the winner
  always_comb begin
    winner_id    = '0;
    any_eligible = |w_eligible;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        winner_id = IRQ_ID_W'(i);
      end
    end
  end

  // A new edge on a channel being cleared re-arms it (set wins)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_prev <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
    end else begin
      r_irq_prev <= irq;
      r_pend     <= (r_pend & ~w_clr) | w_rise;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/exc_step4_ctrl.sv
// ============================================================================
// Module : exc_step4_ctrl
// Brief  : Step-4 exception/interrupt controller: capture, flush, redirect, eret.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exc_step4_ctrl
  import exc_pkg::*;
#(
  parameter int                N_IRQ    = 4,
  parameter int                CAUSE_W  = 3,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] VEC_ADDR = ADDR_W'(32'h0000_0180)
) (
  input wire logic          clk,
  input wire logic          reset,
  exc_step4_ctrl_if.slave   bus
);

  localparam int                 IRQ_ID_W    = irq_id_width(N_IRQ);
  localparam logic [CAUSE_W-1:0] c_cause_irq = CAUSE_W'(CAUSE_IRQ);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CAUSE_W-1:0]   r_cause;
  logic [IRQ_ID_W-1:0]  r_irq_id;
  logic [ADDR_W-1:0]    r_epc;
  logic                 r_double_fault;

  logic                 w_exc_req;
  logic                 w_take_exc;
  logic                 w_take_irq;
  logic                 w_any_eligible;
  logic [IRQ_ID_W-1:0]  w_winner_id;

  irq_pending_prio #(
    .N_IRQ    (N_IRQ),
    .IRQ_ID_W (IRQ_ID_W)
  ) u_irq_pending_prio (
    .clk          (clk),
    .reset        (reset),
    .irq          (bus.irq),
    .mask_we      (bus.mask_we),
    .mask_wdata   (bus.mask_wdata),
    .take_clr     (w_take_irq),
    .any_eligible (w_any_eligible),
    .winner_id    (w_winner_id)
  );

  // Synchronous exceptions pre-empt interrupts; the interrupt stays pending
  assign w_exc_req  = (bus.cause_step3 != '0);
  assign w_take_exc = (r_state == IDLE) && w_exc_req;
  assign w_take_irq = (r_state == IDLE) && !w_exc_req && w_any_eligible;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take_exc || w_take_irq) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = HANDLER;
      HANDLER: if (bus.eret) w_state_nxt = RETURN;
      RETURN:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cause        <= '0;
      r_irq_id       <= '0;
      r_epc          <= '0;
      r_double_fault <= 1'b0;
    end else begin
      if (w_take_exc) begin
        r_cause <= bus.cause_step3;
        r_epc   <= bus.pc_step4;
      end else if (w_take_irq) begin
        r_cause  <= c_cause_irq;
        r_irq_id <= w_winner_id;
        r_epc    <= bus.pc_step4;
      end
      // A fault inside the handler is recorded but never re-entered
      if ((r_state == HANDLER) && w_exc_req) begin
        r_double_fault <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.flush_step4  = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.load_step4   = 1'b1;
    bus.in_handler   = 1'b0;
    bus.dm_w         = 1'b0;
    case (r_state)
      FLUSH: begin
        bus.flush_step4 = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = VEC_ADDR;
        bus.load_step4  = 1'b0;
      end
      RETURN: begin
        bus.flush_step4 = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = r_epc;
        bus.load_step4  = 1'b0;
      end
      HANDLER: begin
        bus.in_handler = 1'b1;
        bus.dm_w       = (bus.opcode == OPCODE_SW);
      end
      default: begin
        bus.dm_w = (bus.opcode == OPCODE_SW) && !w_take_exc && !w_take_irq;
      end
    endcase
  end

  assign bus.cause_step4  = r_cause;
  assign bus.irq_id       = r_irq_id;
  assign bus.epc          = r_epc;
  assign bus.double_fault = r_double_fault;

endmodule

`default_nettype wire

// File: tb/tb_exc_step4_ctrl.sv
// ============================================================================
// Module : tb_exc_step4_ctrl
// Brief  : Directed self-checking bench for exc_step4_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exc_step4_ctrl;
  import exc_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  exc_step4_ctrl_if #(.N_IRQ(4), .CAUSE_W(3), .ADDR_W(32)) bus ();

  exc_step4_ctrl #(
    .N_IRQ(4), .CAUSE_W(3), .ADDR_W(32), .VEC_ADDR(32'h0000_0180)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.irq = '0; bus.opcode = OPCODE_SW; bus.pc_step4 = '0; bus.cause_step3 = '0;
    bus.eret = 1'b0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    tick();
    checks++; if (bus.dm_w !== 1'b1) begin failures++; $display("FAIL rst_dm_w got=%b exp=1", bus.dm_w); end
    checks++; if (bus.load_step4 !== 1'b1) begin failures++; $display("FAIL rst_load got=%b exp=1", bus.load_step4); end
    checks++; if ({bus.flush_step4, bus.redirect, bus.in_handler, bus.double_fault} !== 4'b0000) begin
      failures++; $display("FAIL rst_flags got=%b exp=0000", {bus.flush_step4, bus.redirect, bus.in_handler, bus.double_fault}); end
    checks++; if ({bus.epc, bus.redirect_pc, bus.cause_step4, bus.irq_id} !== '0) begin
      failures++; $display("FAIL rst_regs epc=%h rpc=%h cause=%0d id=%0d exp=0", bus.epc, bus.redirect_pc, bus.cause_step4, bus.irq_id); end
    reset = 1'b1;
    tick();
    checks++; if (bus.dm_w !== 1'b1 || bus.flush_step4 !== 1'b0 || bus.in_handler !== 1'b0) begin
      failures++; $display("FAIL post_rst dm_w=%b flush=%b inh=%b exp=1,0,0", bus.dm_w, bus.flush_step4, bus.in_handler); end
    bus.opcode = OPCODE_EMPTY; #1;
    checks++; if (bus.dm_w !== 1'b0) begin failures++; $display("FAIL dm_w_empty got=%b exp=0", bus.dm_w); end
    bus.opcode = OPCODE_SYSCALL; #1;
    checks++; if (bus.dm_w !== 1'b0) begin failures++; $display("FAIL dm_w_syscall got=%b exp=0", bus.dm_w); end
    bus.opcode = OPCODE_SW;
  endtask

  task automatic test_irq_priority();
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111;
    tick();
    bus.mask_we = 1'b0; bus.irq = 4'b0110; bus.pc_step4 = 32'h40;
    tick();
    checks++; if (bus.flush_step4 !== 1'b0 || bus.dm_w !== 1'b0) begin
      failures++; $display("FAIL prio_take flush=%b dm_w=%b exp=0,0", bus.flush_step4, bus.dm_w); end
    tick();
    checks++; if (bus.flush_step4 !== 1'b1 || bus.redirect !== 1'b1 || bus.load_step4 !== 1'b0) begin
      failures++; $display("FAIL prio_flush flush=%b redir=%b load=%b exp=1,1,0", bus.flush_step4, bus.redirect, bus.load_step4); end
    checks++; if (bus.redirect_pc !== 32'h180) begin failures++; $display("FAIL prio_vec got=%h exp=00000180", bus.redirect_pc); end
    checks++; if (bus.irq_id !== 2'd1 || bus.cause_step4 !== 3'd0) begin
      failures++; $display("FAIL prio_id id=%0d cause=%0d exp=1,0", bus.irq_id, bus.cause_step4); end
    checks++; if (bus.epc !== 32'h40) begin failures++; $display("FAIL prio_epc got=%h exp=00000040", bus.epc); end
    tick();
    checks++; if (bus.in_handler !== 1'b1 || bus.flush_step4 !== 1'b0 || bus.dm_w !== 1'b1) begin
      failures++; $display("FAIL prio_handler inh=%b flush=%b dm_w=%b exp=1,0,1", bus.in_handler, bus.flush_step4, bus.dm_w); end
  endtask

  task automatic test_eret();
    bus.eret = 1'b1;
    tick();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h40 || bus.in_handler !== 1'b0) begin
      failures++; $display("FAIL eret_redir redir=%b rpc=%h inh=%b exp=1,00000040,0", bus.redirect, bus.redirect_pc, bus.in_handler); end
    bus.eret = 1'b0; bus.pc_step4 = 32'h80;
    tick();
    checks++; if (bus.flush_step4 !== 1'b0 || bus.in_handler !== 1'b0 || bus.dm_w !== 1'b0) begin
      failures++; $display("FAIL eret_idle flush=%b inh=%b dm_w=%b exp=0,0,0", bus.flush_step4, bus.in_handler, bus.dm_w); end
    tick();
    checks++; if (bus.flush_step4 !== 1'b1 || bus.irq_id !== 2'd2 || bus.epc !== 32'h80) begin
      failures++; $display("FAIL eret_pend2 flush=%b id=%0d epc=%h exp=1,2,00000080", bus.flush_step4, bus.irq_id, bus.epc); end
    tick();
    bus.eret = 1'b1; tick();
    bus.eret = 1'b0; tick();
    checks++; if (bus.dm_w !== 1'b1 || bus.flush_step4 !== 1'b0) begin
      failures++; $display("FAIL eret_drained dm_w=%b flush=%b exp=1,0", bus.dm_w, bus.flush_step4); end
  endtask

  task automatic test_exception();
    bus.irq = 4'b0001; bus.cause_step3 = 3'd3; bus.pc_step4 = 32'hC0; #1;
    checks++; if (bus.dm_w !== 1'b0) begin failures++; $display("FAIL exc_dm_w got=%b exp=0", bus.dm_w); end
    tick();
    checks++; if (bus.cause_step4 !== 3'd3 || bus.epc !== 32'hC0 || bus.flush_step4 !== 1'b1) begin
      failures++; $display("FAIL exc_capture cause=%0d epc=%h flush=%b exp=3,000000c0,1", bus.cause_step4, bus.epc, bus.flush_step4); end
    bus.cause_step3 = '0;
    tick();
    bus.eret = 1'b1; tick();
    checks++; if (bus.redirect_pc !== 32'hC0) begin failures++; $display("FAIL exc_ret_pc got=%h exp=000000c0", bus.redirect_pc); end
    bus.eret = 1'b0; bus.pc_step4 = 32'hD0; tick();
    tick();
    checks++; if (bus.flush_step4 !== 1'b1 || bus.irq_id !== 2'd0 || bus.cause_step4 !== 3'd0 || bus.epc !== 32'hD0) begin
      failures++; $display("FAIL exc_kept_irq0 flush=%b id=%0d cause=%0d epc=%h exp=1,0,0,000000d0",
                           bus.flush_step4, bus.irq_id, bus.cause_step4, bus.epc); end
    tick();
    bus.eret = 1'b1; tick();
    bus.eret = 1'b0; tick();
  endtask

  task automatic test_mask();
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b0000; bus.irq = 4'b1000;
    tick();
    bus.mask_we = 1'b0;
    checks++; if (bus.flush_step4 !== 1'b0 || bus.dm_w !== 1'b1) begin
      failures++; $display("FAIL mask_hold1 flush=%b dm_w=%b exp=0,1", bus.flush_step4, bus.dm_w); end
    tick();
    checks++; if (bus.flush_step4 !== 1'b0 || bus.in_handler !== 1'b0) begin
      failures++; $display("FAIL mask_hold2 flush=%b inh=%b exp=0,0", bus.flush_step4, bus.in_handler); end
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1000; bus.pc_step4 = 32'h100;
    tick();
    bus.mask_we = 1'b0;
    checks++; if (bus.flush_step4 !== 1'b0 || bus.dm_w !== 1'b0) begin
      failures++; $display("FAIL mask_en flush=%b dm_w=%b exp=0,0", bus.flush_step4, bus.dm_w); end
    tick();
    checks++; if (bus.flush_step4 !== 1'b1 || bus.irq_id !== 2'd3 || bus.epc !== 32'h100) begin
      failures++; $display("FAIL mask_take flush=%b id=%0d epc=%h exp=1,3,00000100", bus.flush_step4, bus.irq_id, bus.epc); end
    tick();
  endtask

  task automatic test_double_fault();
    bus.cause_step3 = 3'd5;
    tick();
    checks++; if (bus.double_fault !== 1'b1 || bus.in_handler !== 1'b1 || bus.cause_step4 !== 3'd0) begin
      failures++; $display("FAIL dfault_set df=%b inh=%b cause=%0d exp=1,1,0", bus.double_fault, bus.in_handler, bus.cause_step4); end
    bus.cause_step3 = '0;
    tick();
    checks++; if (bus.double_fault !== 1'b1 || bus.in_handler !== 1'b1) begin
      failures++; $display("FAIL dfault_sticky df=%b inh=%b exp=1,1", bus.double_fault, bus.in_handler); end
    bus.eret = 1'b1; bus.cause_step3 = 3'd2;
    tick();
    checks++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h100 || bus.double_fault !== 1'b1) begin
      failures++; $display("FAIL dfault_eret redir=%b rpc=%h df=%b exp=1,00000100,1", bus.redirect, bus.redirect_pc, bus.double_fault); end
    bus.eret = 1'b0; bus.cause_step3 = '0;
    tick();
  endtask

  task automatic test_reset_mid_flush();
    bus.irq = 4'b0000; tick();
    bus.irq = 4'b1000; tick();
    tick();
    checks++; if (bus.flush_step4 !== 1'b1) begin failures++; $display("FAIL rflush_pre got=%b exp=1", bus.flush_step4); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.flush_step4 !== 1'b0 || bus.redirect !== 1'b0 || bus.load_step4 !== 1'b1) begin
      failures++; $display("FAIL rflush_out flush=%b redir=%b load=%b exp=0,0,1", bus.flush_step4, bus.redirect, bus.load_step4); end
    checks++; if (bus.redirect_pc !== 32'h0 || bus.double_fault !== 1'b0 || bus.epc !== 32'h0) begin
      failures++; $display("FAIL rflush_regs rpc=%h df=%b epc=%h exp=0,0,0", bus.redirect_pc, bus.double_fault, bus.epc); end
    tick();
    reset = 1'b1;
    tick(); tick();
    checks++; if (bus.flush_step4 !== 1'b0 || bus.in_handler !== 1'b0) begin
      failures++; $display("FAIL rflush_after flush=%b inh=%b exp=0,0", bus.flush_step4, bus.in_handler); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_irq_priority();
    test_eret();
    test_exception();
    test_mask();
    test_double_fault();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
